lsu_byte_master: RTL and testbench

//  Load/store initiator between the MIPS MEM stage and a byte-wide data memory port.

---
 rtl/lsu_byte_master.sv | 133 +++++++++++++
 tb/tb_lsu_byte_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_master.sv
// Load/store initiator: splits byte/half/word requests into little-endian byte beats on a
// byte-wide memory port, reassembles and extends load data, rejects illegal/misaligned ops.
module lsu_byte_master #(
  parameter int RD_LAT      = 0,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic        req_signo,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  typedef enum logic [1:0] {IDLE, BEAT, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic        we_q, signo_q, err_q, pend;
  logic [1:0]  nb_q, idx, pidx, idx_n, samp_idx;
  logic [31:0] wdata_q, lanes, asm_d, ext_d;
  logic        accept, legal, req_err, last, samp_en;

  always_comb begin
    legal   = (req_op == 3'b001) || (req_op == 3'b010) || (req_op == 3'b100);
    req_err = !legal || (CHECK_ALIGN && ((req_op == 3'b010 && req_addr[0]) ||
                                         (req_op == 3'b100 && req_addr[1:0] != 2'b00)));
  end

  assign last  = (idx == nb_q);
  assign idx_n = idx + 2'd1;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_nx = req_err ? RESP : BEAT;
      end
      BEAT: if (last) state_nx = (!we_q && RD_LAT == 1) ? WAIT : RESP;
      WAIT: state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With RD_LAT=1 the byte returned now belongs to the previous cycle's address beat.
  always_comb begin
    if (RD_LAT == 1) begin
      samp_en  = pend;
      samp_idx = pidx;
    end else begin
      samp_en  = (state == BEAT) && !we_q;
      samp_idx = idx;
    end
    asm_d = lanes;
    if (samp_en) asm_d[{samp_idx, 3'b000} +: 8] = mem_dout;
    case (nb_q)
      2'd0:    ext_d = {{24{signo_q & asm_d[7]}}, asm_d[7:0]};
      2'd1:    ext_d = {{16{signo_q & asm_d[15]}}, asm_d[15:0]};
      default: ext_d = asm_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      signo_q   <= 1'b0;
      err_q     <= 1'b0;
      nb_q      <= 2'd0;
      wdata_q   <= 32'd0;
      idx       <= 2'd0;
      pend      <= 1'b0;
      pidx      <= 2'd0;
      lanes     <= 32'd0;
      rsp_rdata <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_din   <= 8'd0;
    end else begin
      state <= state_nx;
      pend  <= (state == BEAT) && !we_q && (RD_LAT == 1);
      pidx  <= idx;
      if (samp_en) lanes <= asm_d;
      if (accept) begin
        we_q    <= req_we;
        signo_q <= req_signo;
        err_q   <= req_err;
        nb_q    <= (req_op == 3'b100) ? 2'd3 : (req_op == 3'b010) ? 2'd1 : 2'd0;
        wdata_q <= req_wdata;
        idx     <= 2'd0;
        lanes   <= 32'd0;
        // Rejected requests leave the memory port untouched.
        if (!req_err) begin
          mem_we   <= req_we;
          mem_addr <= req_addr;
          mem_din  <= req_wdata[7:0];
        end
      end
      if (state == BEAT) begin
        if (last) begin
          mem_we <= 1'b0;
        end else begin
          idx      <= idx_n;
          mem_addr <= mem_addr + 32'd1;
          mem_din  <= wdata_q[{idx_n, 3'b000} +: 8];
        end
      end
      if (!we_q && (state == BEAT || state == WAIT) && state_nx == RESP)
        rsp_rdata <= ext_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Bench for lsu_byte_master: RD_LAT=0 and RD_LAT=1 instances share stimulus and are
// checked against a byte-array memory model and a per-request response model.
module tb_lsu_byte_master;

  logic clk = 1'b0;
  logic rst_n, mem_clr;
  logic req_valid, req_we, req_signo;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_valid, rsp_err, mem_we;
  logic [1:0][31:0] rsp_rdata, mem_addr;
  logic [1:0][7:0]  mem_din;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  refm [64];
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    logic [7:0]  mem [64];
    logic [7:0]  dout;
    logic [31:0] addr_d;
    int          wcnt;

    lsu_byte_master #(.RD_LAT(k), .CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready[k]), .req_we(req_we),
      .req_op(req_op), .req_signo(req_signo), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[k]), .rsp_err(rsp_err[k]), .rsp_rdata(rsp_rdata[k]),
      .mem_we(mem_we[k]), .mem_addr(mem_addr[k]), .mem_din(mem_din[k]), .mem_dout(dout)
    );

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int j = 0; j < 64; j++) mem[j] <= 8'h00;
        wcnt <= 0;
      end else if (mem_we[k]) begin
        mem[mem_addr[k][5:0]] <= mem_din[k];
        wcnt <= wcnt + 1;
      end
      addr_d <= mem_addr[k];
    end

    always @(negedge clk) begin
      logic [5:0] sel;
      sel  = (k == 1) ? addr_d[5:0] : mem_addr[k][5:0];
      dout = mem[sel];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] addr, logic [2:0] op, logic sg);
    int nb;
    logic [31:0] v, a;
    nb = (op == 3'b100) ? 4 : (op == 3'b010) ? 2 : 1;
    v  = 32'd0;
    for (int i = 0; i < nb; i++) begin
      a = addr + i;
      v = v | (32'(refm[a[5:0]]) << (8 * i));
    end
    if (op == 3'b001 && sg && v[7])  v = v | 32'hFFFF_FF00;
    if (op == 3'b010 && sg && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (req_ready != 2'b11 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) check("idle_timeout", {30'd0, req_ready}, 32'd3);
  endtask

  task automatic check_mem(input logic [31:0] a);
    check("mem0", {24'd0, g[0].mem[a[5:0]]}, {24'd0, refm[a[5:0]]});
    check("mem1", {24'd0, g[1].mem[a[5:0]]}, {24'd0, refm[a[5:0]]});
  endtask

  task automatic do_req(input logic we, input logic [2:0] op, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
    int nb, lat0, lat1, w0, w1;
    logic err;
    logic [31:0] exp_new, a;
    nb   = (op == 3'b100) ? 4 : (op == 3'b010) ? 2 : 1;
    err  = !(op == 3'b001 || op == 3'b010 || op == 3'b100) ||
           (op == 3'b010 && addr[0]) || (op == 3'b100 && addr[1:0] != 2'b00);
    lat0 = err ? 1 : nb + 1;
    lat1 = err ? 1 : nb + 1 + (we ? 0 : 1);
    exp_new = (!we && !err) ? model_load(addr, op, sg) : exp_rd;
    wait_idle();
    w0 = g[0].wcnt;
    w1 = g[1].wcnt;
    req_we = we; req_op = op; req_signo = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= nb + 4; c++) begin
      check("rdy0", {31'd0, req_ready[0]}, {31'd0, c > lat0});
      check("rdy1", {31'd0, req_ready[1]}, {31'd0, c > lat1});
      check("vld0", {31'd0, rsp_valid[0]}, {31'd0, c == lat0});
      check("vld1", {31'd0, rsp_valid[1]}, {31'd0, c == lat1});
      if (rsp_valid[0]) check("err0", {31'd0, rsp_err[0]}, {31'd0, err});
      if (rsp_valid[1]) check("err1", {31'd0, rsp_err[1]}, {31'd0, err});
      check("rdata0", rsp_rdata[0], (c >= lat0) ? exp_new : exp_rd);
      check("rdata1", rsp_rdata[1], (c >= lat1) ? exp_new : exp_rd);
      @(negedge clk);
    end
    exp_rd = exp_new;
    check("wcnt0", g[0].wcnt - w0, (we && !err) ? nb : 0);
    check("wcnt1", g[1].wcnt - w1, (we && !err) ? nb : 0);
    if (we && !err) begin
      for (int i = 0; i < nb; i++) begin
        a = addr + i;
        refm[a[5:0]] = wd[8*i +: 8];
        check_mem(a);
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    int r;
    rst_n = 1'b0; mem_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
    req_signo = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; exp_rd = 32'd0;
    for (int j = 0; j < 64; j++) refm[j] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'd0, req_ready}, 32'd3);
    check("rst_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_err",   {30'd0, rsp_err},   32'd0);
    check("rst_we",    {30'd0, mem_we},    32'd0);
    check("rst_rdata0", rsp_rdata[0], 32'd0);
    check("rst_rdata1", rsp_rdata[1], 32'd0);
    check("rst_addr0", mem_addr[0], 32'd0);
    check("rst_addr1", mem_addr[1], 32'd0);
    check("rst_din", {16'd0, mem_din}, 32'd0);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(negedge clk);

    do_req(1'b1, 3'b100, 1'b0, 32'h8, 32'h1122_3344);
    check("st_w8",  {24'd0, g[0].mem[8]},  32'h44);
    check("st_w9",  {24'd0, g[0].mem[9]},  32'h33);
    check("st_wA",  {24'd0, g[0].mem[10]}, 32'h22);
    check("st_wB",  {24'd0, g[0].mem[11]}, 32'h11);

    do_req(1'b1, 3'b001, 1'b0, 32'h10, 32'h80);
    do_req(1'b0, 3'b001, 1'b1, 32'h10, 32'h0);
    check("ldb_s0", rsp_rdata[0], 32'hFFFF_FF80);
    check("ldb_s1", rsp_rdata[1], 32'hFFFF_FF80);
    do_req(1'b0, 3'b001, 1'b0, 32'h10, 32'h0);
    check("ldb_u0", rsp_rdata[0], 32'h0000_0080);

    do_req(1'b1, 3'b010, 1'b0, 32'h12, 32'hF234);
    do_req(1'b0, 3'b010, 1'b1, 32'h12, 32'h0);
    check("ldh_s0", rsp_rdata[0], 32'hFFFF_F234);
    check("ldh_s1", rsp_rdata[1], 32'hFFFF_F234);
    do_req(1'b0, 3'b010, 1'b0, 32'h12, 32'h0);
    check("ldh_u1", rsp_rdata[1], 32'h0000_F234);

    do_req(1'b0, 3'b100, 1'b0, 32'h6, 32'h0);
    do_req(1'b0, 3'b011, 1'b0, 32'h0, 32'h0);
    check("err_keep0", rsp_rdata[0], 32'h0000_F234);

    do_req(1'b1, 3'b001, 1'b0, 32'hFFFF_FFFF, 32'hC3);
    check("wrap_st", {24'd0, g[0].mem[63]}, 32'hC3);
    do_req(1'b0, 3'b100, 1'b0, 32'h0, 32'h0);
    do_req(1'b0, 3'b100, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check("wrap_ld", rsp_rdata[0], 32'hC300_0000);

    // Back-to-back byte stores with req_valid held high.
    wait_idle();
    req_we = 1'b1; req_op = 3'b001; req_signo = 1'b0; req_addr = 32'h20; req_wdata = 32'hA5;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h21; req_wdata = 32'h5A;
    for (int c = 1; c <= 7; c++) begin
      check("b2b_vld0", {31'd0, rsp_valid[0]}, {31'd0, c == 2 || c == 5});
      check("b2b_vld1", {31'd0, rsp_valid[1]}, {31'd0, c == 2 || c == 5});
      check("b2b_rdy", {31'd0, req_ready[0]}, {31'd0, c == 3 || c >= 6});
      if (c == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    refm[32] = 8'hA5; refm[33] = 8'h5A;
    check_mem(32'h20);
    check_mem(32'h21);

    // Reset in beat 2 of a word store.
    wait_idle();
    req_we = 1'b1; req_op = 3'b100; req_addr = 32'h28; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("ar_ready", {30'd0, req_ready}, 32'd3);
    check("ar_we",    {30'd0, mem_we},    32'd0);
    check("ar_valid", {30'd0, rsp_valid}, 32'd0);
    check("ar_err",   {30'd0, rsp_err},   32'd0);
    check("ar_rdata", rsp_rdata[0], 32'd0);
    check("ar_addr",  mem_addr[1], 32'd0);
    check("ar_din",   {16'd0, mem_din}, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("ar_novld", {30'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    exp_rd = 32'd0;
    refm[40] = 8'hEF; refm[41] = 8'hBE;
    for (int i = 40; i < 44; i++) check_mem(i);
    do_req(1'b0, 3'b100, 1'b0, 32'h28, 32'h0);
    check("ar_after", rsp_rdata[0], 32'h0000_BEEF);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 3'b001 : (r < 6) ? 3'b010 : (r < 9) ? 3'b100 : 3'($urandom_range(0, 7));
      addr = {($urandom_range(0, 3) == 0) ? 26'h3FF_FFFF : 26'h0, 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 3) != 0) begin
        if (op == 3'b010) addr[0] = 1'b0;
        if (op == 3'b100) addr[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), addr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
